// File: rtl/mmio_read_return.sv
// MMIO read-return arbiter: priority-selects one read source, strobes it and returns its data.
// Optional WAIT timeout is compiled in with `define MMIO_READ_TIMEOUT_EN.
module mmio_read_return #(
  parameter int unsigned     NCH      = 5,
  parameter int unsigned     DW       = 32,
  parameter int unsigned     TMO_CYC  = 255,
  parameter logic [DW-1:0]   ERR_DATA = DW'(32'hDEAD_BEEF)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [NCH-1:0]    rd_sel,
  output logic              rd_busy,
  output logic              rd_valid,
  output logic [DW-1:0]     rd_data,
  output logic              rd_err,
  output logic              multi_hit,
  output logic [NCH-1:0]    src_rd_en,
  input  logic [NCH-1:0]    src_ack,
  input  logic [NCH*DW-1:0] src_data
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

  state_t         r_state;
  logic [NCH-1:0] r_sel;
  logic           r_empty;

  logic [NCH-1:0] w_lowest;
  logic           w_multi;
  logic           w_hit;
  logic [DW-1:0]  w_sel_data;
  logic           w_tmo;

  // Two's-complement trick isolates the lowest set bit (index 0 wins).
  assign w_lowest = rd_sel & (~rd_sel + NCH'(1));
  assign w_multi  = (rd_sel & (rd_sel - NCH'(1))) != '0;
  assign w_hit    = (src_ack & r_sel) != '0;

  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < NCH; i++) begin
      if (r_sel[i]) begin
        w_sel_data = w_sel_data | src_data[i*DW +: DW];
      end
    end
  end

`ifdef MMIO_READ_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TMO_CYC + 1);

  logic [CW-1:0] r_cnt;
  logic          r_err;

  assign w_tmo  = (r_cnt == CW'(TMO_CYC));
  assign rd_err = r_err;
`else
  logic w_unused_cfg;

  assign w_unused_cfg = (^ERR_DATA) ^ (TMO_CYC != 0);
  assign w_tmo        = 1'b0;
  assign rd_err       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_sel     <= '0;
      r_empty   <= 1'b0;
      rd_busy   <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      multi_hit <= 1'b0;
      src_rd_en <= '0;
`ifdef MMIO_READ_TIMEOUT_EN
      r_cnt     <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      rd_valid  <= 1'b0;
      src_rd_en <= '0;
      unique case (r_state)
        StIdle: begin
          if (rd_req) begin
            // An empty decode still passes through one WAIT cycle so it returns with
            // the same latency as a zero-wait source; its strobe is all-zero.
            r_state   <= StWait;
            rd_busy   <= 1'b1;
            r_sel     <= w_lowest;
            r_empty   <= (rd_sel == '0);
            src_rd_en <= w_lowest;
            if (w_multi) begin
              multi_hit <= 1'b1;
            end
`ifdef MMIO_READ_TIMEOUT_EN
            r_cnt     <= '0;
`endif
          end
        end
        StWait: begin
          if (r_empty) begin
            r_state  <= StResp;
            rd_valid <= 1'b1;
            rd_data  <= '0;
`ifdef MMIO_READ_TIMEOUT_EN
            r_err    <= 1'b0;
`endif
          end else if (w_hit) begin
            r_state  <= StResp;
            rd_valid <= 1'b1;
            rd_data  <= w_sel_data;
`ifdef MMIO_READ_TIMEOUT_EN
            r_err    <= 1'b0;
`endif
          end else if (w_tmo) begin
            r_state  <= StResp;
            rd_valid <= 1'b1;
            rd_data  <= ERR_DATA;
`ifdef MMIO_READ_TIMEOUT_EN
            r_err    <= 1'b1;
`endif
          end else begin
`ifdef MMIO_READ_TIMEOUT_EN
            r_cnt <= r_cnt + CW'(1);
`endif
          end
        end
        StResp: begin
          r_state <= StIdle;
          rd_busy <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          rd_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_read_return.sv
// Randomized bench for mmio_read_return with a transaction-level reference model.
// Timeout scenarios are exercised only when MMIO_READ_TIMEOUT_EN is defined.
module tb_mmio_read_return;

  localparam int unsigned NCH = 5;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 4;
`ifdef MMIO_READ_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rd_req;
  logic [NCH-1:0]    rd_sel;
  logic              rd_busy;
  logic              rd_valid;
  logic [DW-1:0]     rd_data;
  logic              rd_err;
  logic              multi_hit;
  logic [NCH-1:0]    src_rd_en;
  logic [NCH-1:0]    src_ack;
  logic [NCH*DW-1:0] src_data;

  int n_vec = 0;
  int n_err = 0;

  mmio_read_return #(
    .NCH      (NCH),
    .DW       (DW),
    .TMO_CYC  (TMO),
    .ERR_DATA (32'hDEAD_BEEF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_req    (rd_req),
    .rd_sel    (rd_sel),
    .rd_busy   (rd_busy),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .rd_err    (rd_err),
    .multi_hit (multi_hit),
    .src_rd_en (src_rd_en),
    .src_ack   (src_ack),
    .src_data  (src_data)
  );

  always #5 clk = ~clk;

  // Reference model: a transaction is idle, waiting (with its age in WAIT cycles) or responding.
  int             m_ph  = 0;  // 0 idle, 1 waiting, 2 responding
  int             m_ch  = -1;
  int             m_age = 0;
  logic           e_busy, e_valid, e_err, e_mh;
  logic [DW-1:0]  e_data;
  logic [NCH-1:0] e_en;

  task automatic respond(input logic [DW-1:0] d, input logic er);
    m_ph   = 2;
    e_data = d;
    e_err  = er;
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_ph = 0; m_age = 0; e_data = '0; e_err = 1'b0; e_mh = 1'b0;
    end else if (m_ph == 0) begin
      if (rd_req) begin
        m_ph = 1; m_age = 0; m_ch = -1;
        for (int i = NCH - 1; i >= 0; i--) if (rd_sel[i]) m_ch = i;
        if ($countones(rd_sel) > 1) e_mh = 1'b1;
      end
    end else if (m_ph == 1) begin
      if (m_ch < 0) respond('0, 1'b0);
      else if (src_ack[m_ch]) respond(src_data[m_ch*DW +: DW], 1'b0);
      else if (TmoEn && m_age == TMO) respond(32'hDEAD_BEEF, 1'b1);
      else m_age++;
    end else begin
      m_ph = 0;
    end
    e_busy  = (m_ph != 0);
    e_valid = (m_ph == 2);
    e_en    = (m_ph == 1 && m_age == 0 && m_ch >= 0) ? (NCH'(1) << m_ch) : '0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Apply the current inputs for one cycle, then compare every output against the model.
  task automatic step();
    model_step();
    @(negedge clk);
    chk("busy", {31'b0, rd_busy}, {31'b0, e_busy});
    chk("valid", {31'b0, rd_valid}, {31'b0, e_valid});
    chk("data", rd_data, e_data);
    chk("err", {31'b0, rd_err}, {31'b0, e_err});
    chk("multi_hit", {31'b0, multi_hit}, {31'b0, e_mh});
    chk("src_rd_en", {27'b0, src_rd_en}, {27'b0, e_en});
  endtask

  task automatic idle_in();
    rd_req  = 1'b0;
    rd_sel  = '0;
    src_ack = '0;
  endtask

  int nv, ns;

  initial begin
    rst_n = 1'b0; src_data = '0; idle_in();
    step(); step();
    chk("rst_busy", {31'b0, rd_busy}, 0);
    chk("rst_data", rd_data, 0);
    rst_n = 1'b1;
    step();

    // Zero-wait source 2.
    src_data[2*DW +: DW] = 32'h0000_00A5;
    rd_req = 1'b1; rd_sel = 5'b00100; src_ack = 5'b00100;
    step();
    chk("s1_en", {27'b0, src_rd_en}, 32'h4);
    chk("s1_busy", {31'b0, rd_busy}, 1);
    rd_req = 1'b0;
    step();
    chk("s1_valid", {31'b0, rd_valid}, 1);
    chk("s1_data", rd_data, 32'h0000_00A5);
    chk("s1_err", {31'b0, rd_err}, 0);
    chk("s1_en_off", {27'b0, src_rd_en}, 0);
    src_ack = '0;
    step();
    chk("s1_idle", {31'b0, rd_busy}, 0);

    // Two hits: channel 1 wins, multi_hit sticks.
    src_data[1*DW +: DW] = 32'h1111_1111;
    src_data[4*DW +: DW] = 32'h4444_4444;
    rd_req = 1'b1; rd_sel = 5'b10010; src_ack = 5'b10010;
    step();
    chk("s2_en", {27'b0, src_rd_en}, 32'h2);
    chk("s2_mh", {31'b0, multi_hit}, 1);
    rd_req = 1'b0;
    step();
    chk("s2_data", rd_data, 32'h1111_1111);
    idle_in();
    step();
    src_data[3*DW +: DW] = 32'h3333_3333;
    rd_req = 1'b1; rd_sel = 5'b01000; src_ack = 5'b01000;
    step();
    rd_req = 1'b0;
    step();
    chk("s2_clean_data", rd_data, 32'h3333_3333);
    chk("s2_mh_sticky", {31'b0, multi_hit}, 1);
    idle_in();
    step();

    // Empty decode.
    rd_req = 1'b1; rd_sel = '0;
    step();
    chk("s3_en", {27'b0, src_rd_en}, 0);
    chk("s3_novalid", {31'b0, rd_valid}, 0);
    rd_req = 1'b0;
    step();
    chk("s3_valid", {31'b0, rd_valid}, 1);
    chk("s3_data", rd_data, 0);
    chk("s3_err", {31'b0, rd_err}, 0);
    step();

`ifdef MMIO_READ_TIMEOUT_EN
    // Selected source silent, unselected one acking: timeout after TMO+1 WAIT cycles.
    rd_req = 1'b1; rd_sel = 5'b00001; src_ack = 5'b00010;
    step();
    rd_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("s4_wait", {31'b0, rd_valid}, 0);
    end
    step();
    chk("s4_valid", {31'b0, rd_valid}, 1);
    chk("s4_err", {31'b0, rd_err}, 1);
    chk("s4_data", rd_data, 32'hDEAD_BEEF);
    src_ack = '0;
    step();
    chk("s4_release", {31'b0, rd_busy}, 0);
`endif

    // Late ack with a second request pulsed during WAIT.
    nv = 0; ns = 0;
    src_data[3*DW +: DW] = 32'h1234_5678;
    rd_req = 1'b1; rd_sel = 5'b01000; src_ack = '0;
    step(); nv += rd_valid; ns += (src_rd_en != '0);
    rd_req = 1'b0;
    step(); nv += rd_valid; ns += (src_rd_en != '0);
    rd_req = 1'b1; rd_sel = 5'b00001;
    step(); nv += rd_valid; ns += (src_rd_en != '0);
    rd_req = 1'b0; src_ack = 5'b01000;
    step(); nv += rd_valid; ns += (src_rd_en != '0);
    chk("s5_data", rd_data, 32'h1234_5678);
    src_ack = '0;
    for (int i = 0; i < 4; i++) begin
      step(); nv += rd_valid; ns += (src_rd_en != '0);
    end
    chk("s5_one_valid", nv, 1);
    chk("s5_one_strobe", ns, 1);

    // Reset in the middle of WAIT, with an ack in the reset cycle.
    src_data[0*DW +: DW] = 32'hCAFE_0001;
    rd_req = 1'b1; rd_sel = 5'b00001;
    step();
    rd_req = 1'b0;
    step();
    rst_n = 1'b0; src_ack = 5'b00001;
    step();
    chk("s6_busy", {31'b0, rd_busy}, 0);
    chk("s6_valid", {31'b0, rd_valid}, 0);
    chk("s6_data", rd_data, 0);
    chk("s6_mh", {31'b0, multi_hit}, 0);
    chk("s6_en", {27'b0, src_rd_en}, 0);
    rst_n = 1'b1; src_ack = '0;
    step();
    chk("s6_no_late_valid", {31'b0, rd_valid}, 0);
    rd_req = 1'b1; rd_sel = 5'b00001; src_ack = 5'b00001;
    step();
    rd_req = 1'b0;
    step();
    chk("s6_after_valid", {31'b0, rd_valid}, 1);
    chk("s6_after_data", rd_data, 32'hCAFE_0001);
    idle_in();
    step();

    // Randomized traffic.
    for (int k = 0; k < 2000; k++) begin
      rst_n  = ($urandom_range(63) != 0);
      rd_req = ($urandom_range(2) == 0);
      case ($urandom_range(3))
        0:       rd_sel = '0;
        1:       rd_sel = NCH'(1) << $urandom_range(NCH - 1);
        default: rd_sel = NCH'($urandom);
      endcase
      for (int i = 0; i < NCH; i++) begin
        src_ack[i] = ($urandom_range(7) == 0);
        src_data[i*DW +: DW] = $urandom;
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
